// File: rtl/present_core_param.sv
// Round-based PRESENT block cipher core with an 80- or 128-bit key.
// It runs one round per clock in either direction. Decryption first
// walks the key schedule forward to the last round key (KEYPREP). It
// then unwinds the schedule on the fly while it runs the inverse rounds.
module present_core_param #(
  parameter int KEY_WIDTH = 80
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 mode,
  input  logic [63:0]          data_in,
  input  logic [KEY_WIDTH-1:0] key,
  output logic                 busy,
  output logic                 done,
  output logic [63:0]          data_out,
  output logic [4:0]           round_count
);

  generate
    if (KEY_WIDTH != 80 && KEY_WIDTH != 128) begin : g_bad_key_width
      $error("present_core_param: KEY_WIDTH must be 80 or 128");
    end
  endgenerate

  // Bit position where the round counter is folded into the key register.
  localparam int CNT_LSB   = (KEY_WIDTH == 128) ? 62 : 15;
  // The 128-bit schedule substitutes two nibbles instead of one.
  localparam bit DUAL_SBOX = (KEY_WIDTH == 128);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_KEYPREP = 2'd1;
  localparam logic [1:0] S_ENC     = 2'd2;
  localparam logic [1:0] S_DEC     = 2'd3;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0:    y = 4'hC;
      4'h1:    y = 4'h5;
      4'h2:    y = 4'h6;
      4'h3:    y = 4'hB;
      4'h4:    y = 4'h9;
      4'h5:    y = 4'h0;
      4'h6:    y = 4'hA;
      4'h7:    y = 4'hD;
      4'h8:    y = 4'h3;
      4'h9:    y = 4'hE;
      4'hA:    y = 4'hF;
      4'hB:    y = 4'h8;
      4'hC:    y = 4'h4;
      4'hD:    y = 4'h7;
      4'hE:    y = 4'h1;
      4'hF:    y = 4'h2;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] inv_sbox4(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0:    y = 4'h5;
      4'h1:    y = 4'hE;
      4'h2:    y = 4'hF;
      4'h3:    y = 4'h8;
      4'h4:    y = 4'hC;
      4'h5:    y = 4'h1;
      4'h6:    y = 4'h2;
      4'h7:    y = 4'hD;
      4'h8:    y = 4'hB;
      4'h9:    y = 4'h4;
      4'hA:    y = 4'h6;
      4'hB:    y = 4'h3;
      4'hC:    y = 4'h0;
      4'hD:    y = 4'h7;
      4'hE:    y = 4'h9;
      4'hF:    y = 4'hA;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

  function automatic logic [63:0] sbox_layer(input logic [63:0] s);
    logic [63:0] r;
    r = 64'd0;
    for (int n = 0; n < 16; n++) begin
      r[6'(4*n) +: 4] = sbox4(s[6'(4*n) +: 4]);
    end
    return r;
  endfunction

  function automatic logic [63:0] inv_sbox_layer(input logic [63:0] s);
    logic [63:0] r;
    r = 64'd0;
    for (int n = 0; n < 16; n++) begin
      r[6'(4*n) +: 4] = inv_sbox4(s[6'(4*n) +: 4]);
    end
    return r;
  endfunction

  // Bit i travels to (16*i) mod 63; bit 63 stays put.
  function automatic logic [63:0] p_layer(input logic [63:0] s);
    logic [63:0] r;
    r = 64'd0;
    for (int i = 0; i < 63; i++) begin
      r[6'((16*i) % 63)] = s[6'(i)];
    end
    r[63] = s[63];
    return r;
  endfunction

  function automatic logic [63:0] inv_p_layer(input logic [63:0] s);
    logic [63:0] r;
    r = 64'd0;
    for (int i = 0; i < 63; i++) begin
      r[6'(i)] = s[6'((16*i) % 63)];
    end
    r[63] = s[63];
    return r;
  endfunction

  // Forward schedule step: rotate left 61, substitute, add the counter.
  function automatic logic [KEY_WIDTH-1:0] key_update(input logic [KEY_WIDTH-1:0] k,
                                                      input logic [4:0] c);
    logic [KEY_WIDTH-1:0] r;
    r = {k[KEY_WIDTH-62:0], k[KEY_WIDTH-1:KEY_WIDTH-61]};
    r[KEY_WIDTH-1 -: 4] = sbox4(r[KEY_WIDTH-1 -: 4]);
    r[KEY_WIDTH-5 -: 4] = DUAL_SBOX ? sbox4(r[KEY_WIDTH-5 -: 4]) : r[KEY_WIDTH-5 -: 4];
    r[CNT_LSB +: 5] = r[CNT_LSB +: 5] ^ c;
    return r;
  endfunction

  // Backward schedule step: undo the counter, undo the S-box, rotate right 61.
  function automatic logic [KEY_WIDTH-1:0] key_inv_update(input logic [KEY_WIDTH-1:0] k,
                                                          input logic [4:0] c);
    logic [KEY_WIDTH-1:0] r;
    r = k;
    r[CNT_LSB +: 5] = r[CNT_LSB +: 5] ^ c;
    r[KEY_WIDTH-1 -: 4] = inv_sbox4(r[KEY_WIDTH-1 -: 4]);
    r[KEY_WIDTH-5 -: 4] = DUAL_SBOX ? inv_sbox4(r[KEY_WIDTH-5 -: 4]) : r[KEY_WIDTH-5 -: 4];
    return {r[60:0], r[KEY_WIDTH-1:61]};
  endfunction

  logic [1:0]           fsm_q, fsm_d;
  logic [63:0]          state_q, state_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic [4:0]           cnt_q, cnt_d;
  logic [63:0]          dout_q, dout_d;
  logic                 done_q, done_d;
  logic                 busy_q;

  logic [KEY_WIDTH-1:0] key_fwd_s;
  logic [KEY_WIDTH-1:0] key_bwd_s;
  logic [63:0]          rk_s;
  logic [63:0]          rk_fwd_s;
  logic [63:0]          enc_round_s;
  logic [63:0]          dec_round_s;

  // Round datapath: next key in both directions and one round each way.
  always_comb begin
    key_fwd_s   = key_update(key_q, cnt_q);
    key_bwd_s   = key_inv_update(key_q, cnt_q);
    rk_s        = key_q[KEY_WIDTH-1 -: 64];
    rk_fwd_s    = key_fwd_s[KEY_WIDTH-1 -: 64];
    enc_round_s = p_layer(sbox_layer(state_q ^ rk_s));
    dec_round_s = inv_sbox_layer(inv_p_layer(state_q)) ^ key_bwd_s[KEY_WIDTH-1 -: 64];
  end

  // Control FSM and next-state selection for state, key, counter and result.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    case (fsm_q)
      S_IDLE: begin
        if (start) begin
          state_d = data_in;
          key_d   = key;
          cnt_d   = 5'd1;
          fsm_d   = mode ? S_KEYPREP : S_ENC;
        end else begin
          fsm_d = S_IDLE;
        end
      end
      S_ENC: begin
        key_d   = key_fwd_s;
        state_d = enc_round_s;
        if (cnt_q == 5'd31) begin
          // The final round carries the post-whitening with round key 32.
          dout_d = enc_round_s ^ rk_fwd_s;
          done_d = 1'b1;
          cnt_d  = 5'd0;
          fsm_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_KEYPREP: begin
        key_d = key_fwd_s;
        if (cnt_q == 5'd31) begin
          // The key register now holds round key 32. Strip the whitening
          // and let DEC unwind from there.
          state_d = state_q ^ rk_fwd_s;
          fsm_d   = S_DEC;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_DEC: begin
        key_d   = key_bwd_s;
        state_d = dec_round_s;
        if (cnt_q == 5'd1) begin
          dout_d = dec_round_s;
          done_d = 1'b1;
          cnt_d  = 5'd0;
          fsm_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      default: begin
        fsm_d = S_IDLE;
        cnt_d = 5'd0;
      end
    endcase
  end

  // State registers with synchronous, dominant reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q   <= S_IDLE;
      state_q <= 64'd0;
      key_q   <= '0;
      cnt_q   <= 5'd0;
      dout_q  <= 64'd0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      busy_q  <= (fsm_d != S_IDLE);
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign data_out    = dout_q;
  assign round_count = cnt_q;

endmodule

// File: tb/tb_present_core_param.sv
// Self-checking bench for present_core_param. It drives one 80-bit and
// one 128-bit instance with known-answer vectors, hand-written handshake
// and reset sequences, and random traffic checked against a reference model.
module tb_present_core_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         start80, start128;
  logic         mode;
  logic [63:0]  din;
  logic [79:0]  key80;
  logic [127:0] key128;

  logic         busy80, done80, busy128, done128;
  logic [63:0]  dout80, dout128;
  logic [4:0]   rc80, rc128;

  present_core_param #(.KEY_WIDTH(80)) dut80 (
    .clk(clk), .reset(reset), .start(start80), .mode(mode), .data_in(din), .key(key80),
    .busy(busy80), .done(done80), .data_out(dout80), .round_count(rc80));

  present_core_param #(.KEY_WIDTH(128)) dut128 (
    .clk(clk), .reset(reset), .start(start128), .mode(mode), .data_in(din), .key(key128),
    .busy(busy128), .done(done128), .data_out(dout128), .round_count(rc128));

  int n_cmp = 0;
  int n_bad = 0;
  int sel_kw = 80;

  logic        cur_busy, cur_done;
  logic [63:0] cur_dout;
  logic [4:0]  cur_rc;

  // Route the outputs of whichever instance is under test.
  always_comb begin
    cur_busy = (sel_kw == 128) ? busy128 : busy80;
    cur_done = (sel_kw == 128) ? done128 : done80;
    cur_dout = (sel_kw == 128) ? dout128 : dout80;
    cur_rc   = (sel_kw == 128) ? rc128   : rc80;
  end

  // ---------------- reference model ----------------
  function automatic logic [3:0] m_sbox(input logic [3:0] x);
    logic [63:0] tbl;
    tbl = 64'hC56B90AD3EF84712;
    return tbl[63 - 4*int'(x) -: 4];
  endfunction

  function automatic logic [3:0] m_isbox(input logic [3:0] x);
    for (int v = 0; v < 16; v++) begin
      if (m_sbox(4'(v)) == x) return 4'(v);
    end
    return 4'h0;
  endfunction

  function automatic logic [63:0] m_sub(input logic [63:0] s, input bit inv);
    logic [63:0] r;
    for (int n = 0; n < 16; n++) begin
      r[4*n +: 4] = inv ? m_isbox(s[4*n +: 4]) : m_sbox(s[4*n +: 4]);
    end
    return r;
  endfunction

  function automatic logic [63:0] m_perm(input logic [63:0] s, input bit inv);
    logic [63:0] r;
    int dst;
    for (int i = 0; i < 64; i++) begin
      dst = (i == 63) ? 63 : (16*i) % 63;
      if (inv) r[i] = s[dst];
      else     r[dst] = s[i];
    end
    return r;
  endfunction

  function automatic logic [63:0] model(input int kw, input logic md,
                                        input logic [63:0] d, input logic [127:0] k);
    logic [127:0] kr, nk;
    logic [63:0]  rk [1:32];
    logic [63:0]  s;
    int pos;
    kr = '0;
    for (int i = 0; i < kw; i++) kr[i] = k[i];
    pos = (kw == 128) ? 62 : 15;
    rk[1] = kr[kw-1 -: 64];
    for (int r = 1; r <= 31; r++) begin
      nk = '0;
      for (int i = 0; i < kw; i++) nk[(i + 61) % kw] = kr[i];
      nk[kw-1 -: 4] = m_sbox(nk[kw-1 -: 4]);
      if (kw == 128) nk[123:120] = m_sbox(nk[123:120]);
      nk[pos +: 5] = nk[pos +: 5] ^ 5'(r);
      kr = nk;
      rk[r+1] = kr[kw-1 -: 64];
    end
    if (!md) begin
      s = d;
      for (int r = 1; r <= 31; r++) s = m_perm(m_sub(s ^ rk[r], 1'b0), 1'b0);
      s = s ^ rk[32];
    end else begin
      s = d ^ rk[32];
      for (int r = 31; r >= 1; r--) s = m_sub(m_perm(s, 1'b1), 1'b1) ^ rk[r];
    end
    return s;
  endfunction

  // round_count expected lat cycles after the accept edge (before done)
  function automatic int exp_rc(input logic md, input int lat);
    if (lat <= 30) return lat + 1;
    if (md && lat <= 61) return 62 - lat;
    return 0;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_start(input int kw, input logic md, input logic [63:0] d,
                             input logic [127:0] k);
    sel_kw   = kw;
    mode     = md;
    din      = d;
    key80    = k[79:0];
    key128   = k;
    start80  = (kw == 80);
    start128 = (kw == 128);
  endtask

  // Launch one operation now and wait (bounded) for done. glitch_at >= 0
  // pulses start with junk inputs at that cycle to prove it is ignored.
  task automatic run_op(input int kw, input logic md, input logic [63:0] d,
                        input logic [127:0] k, input int glitch_at,
                        output logic [63:0] res, output int lat, output bit trace_ok);
    res = 64'd0;
    drive_start(kw, md, d, k);
    @(posedge clk); #1;
    start80 = 1'b0; start128 = 1'b0;
    lat = 0;
    trace_ok = (cur_busy === 1'b1) && (cur_rc === 5'd1) && (cur_done === 1'b0);
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (glitch_at >= 0 && lat == glitch_at + 1) begin
        start80 = 1'b0; start128 = 1'b0;
      end
      if (lat == glitch_at) begin
        din = ~d; mode = ~md;
        if (kw == 128) start128 = 1'b1; else start80 = 1'b1;
      end
      if (cur_done === 1'b1) begin
        res = cur_dout;
        if (cur_busy !== 1'b0 || cur_rc !== 5'd0) trace_ok = 1'b0;
        break;
      end
      if (cur_busy !== 1'b1 || cur_rc !== 5'(exp_rc(md, lat))) trace_ok = 1'b0;
    end
    start80 = 1'b0; start128 = 1'b0;
  endtask

  typedef struct {
    int           kw;
    logic         md;
    logic [63:0]  din;
    logic [127:0] k;
    logic [63:0]  exp;
  } vec_t;

  vec_t vecs [8];

  localparam logic [127:0] K0   = 128'd0;
  localparam logic [127:0] KF80 = {48'h0, 80'hFFFF_FFFF_FFFF_FFFF_FFFF};
  localparam logic [63:0]  ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    logic [63:0] res, ref_v, hold_v;
    int lat, kw;
    bit tr, saw;
    logic md;
    logic [63:0] d;
    logic [127:0] k;

    vecs[0] = '{80,  1'b0, 64'h0,               K0,   64'h5579C1387B228445};
    vecs[1] = '{80,  1'b0, ONES,                KF80, 64'h3333DCD3213210D2};
    vecs[2] = '{80,  1'b0, 64'h0,               KF80, 64'hE72C46C0F5945049};
    vecs[3] = '{80,  1'b0, ONES,                K0,   64'hA112FFC72F68417B};
    vecs[4] = '{128, 1'b0, 64'h0,               K0,   64'h96DB702A2E6900AF};
    vecs[5] = '{128, 1'b1, 64'h96DB702A2E6900AF, K0,  64'h0};
    vecs[6] = '{80,  1'b1, 64'h5579C1387B228445, K0,  64'h0};
    vecs[7] = '{80,  1'b1, 64'h3333DCD3213210D2, KF80, ONES};

    reset = 1'b1; start80 = 1'b0; start128 = 1'b0; mode = 1'b0;
    din = 64'd0; key80 = '0; key128 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy80",  64'(busy80),  64'd0);
    chk("rst_done80",  64'(done80),  64'd0);
    chk("rst_dout80",  dout80,       64'd0);
    chk("rst_rc80",    64'(rc80),    64'd0);
    chk("rst_busy128", 64'(busy128), 64'd0);
    chk("rst_done128", 64'(done128), 64'd0);
    chk("rst_dout128", dout128,      64'd0);
    chk("rst_rc128",   64'(rc128),   64'd0);
    reset = 1'b0;

    // known-answer vectors
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      run_op(vecs[i].kw, vecs[i].md, vecs[i].din, vecs[i].k, -1, res, lat, tr);
      chk($sformatf("kat%0d_result", i), res, vecs[i].exp);
      chk($sformatf("kat%0d_latency", i), 64'(lat), vecs[i].md ? 64'd62 : 64'd31);
      chk($sformatf("kat%0d_busy_rc_trace", i), 64'(tr), 64'd1);
    end

    // result holds while idle, done stays a single pulse
    repeat (5) @(posedge clk);
    #1;
    chk("hold_dout", dout80, ONES);
    chk("hold_done", 64'(done80), 64'd0);

    // start pulsed mid-operation is ignored
    @(negedge clk);
    run_op(80, 1'b0, 64'h0, K0, 10, res, lat, tr);
    chk("glitch_result", res, 64'h5579C1387B228445);
    chk("glitch_latency", 64'(lat), 64'd31);
    chk("glitch_trace", 64'(tr), 64'd1);

    // back-to-back: each new start is raised in the done cycle
    @(negedge clk);
    run_op(80, 1'b0, ONES, KF80, -1, res, lat, tr);
    chk("b2b0_result", res, 64'h3333DCD3213210D2);
    run_op(80, 1'b0, 64'h0, KF80, -1, res, lat, tr);
    chk("b2b1_result", res, 64'hE72C46C0F5945049);
    chk("b2b1_latency", 64'(lat), 64'd31);
    chk("b2b1_trace", 64'(tr), 64'd1);
    run_op(80, 1'b1, 64'hE72C46C0F5945049, KF80, -1, res, lat, tr);
    chk("b2b2_result", res, 64'h0);
    chk("b2b2_latency", 64'(lat), 64'd62);

    // random traffic against the reference model
    for (int i = 0; i < 24; i++) begin
      kw = ($urandom_range(1, 0) == 1) ? 128 : 80;
      md = 1'($urandom_range(1, 0));
      d  = {$urandom, $urandom};
      k  = {$urandom, $urandom, $urandom, $urandom};
      if (kw == 80) k[127:80] = 48'd0;
      ref_v = model(kw, md, d, k);
      @(negedge clk);
      run_op(kw, md, d, k, -1, res, lat, tr);
      chk($sformatf("rnd%0d_kw%0d_m%0d_result", i, kw, md), res, ref_v);
      chk($sformatf("rnd%0d_latency", i), 64'(lat), md ? 64'd62 : 64'd31);
    end

    // reset at cycle 15 of an encrypt aborts it
    @(negedge clk);
    run_op(80, 1'b0, 64'h0, K0, -1, hold_v, lat, tr);
    chk("pre_abort_result", hold_v, 64'h5579C1387B228445);
    @(negedge clk);
    drive_start(80, 1'b0, ONES, KF80);
    @(posedge clk); #1;
    start80 = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", 64'(busy80), 64'd0);
    chk("abort_dout", dout80, 64'd0);
    chk("abort_rc", 64'(rc80), 64'd0);
    saw = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done80 !== 1'b0 || busy80 !== 1'b0) saw = 1'b1;
    end
    chk("abort_no_done", 64'(saw), 64'd0);

    // start together with reset is not accepted
    @(negedge clk);
    reset = 1'b1; start80 = 1'b1; start128 = 1'b1;
    @(posedge clk); #1;
    chk("rst_start_busy80", 64'(busy80), 64'd0);
    chk("rst_start_busy128", 64'(busy128), 64'd0);
    @(negedge clk);
    reset = 1'b0; start80 = 1'b0; start128 = 1'b0;
    @(posedge clk); #1;
    chk("rst_start_idle80", 64'(busy80), 64'd0);
    chk("rst_start_rc80", 64'(rc80), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/present_core_param.md
Name: present_core_param

Overview:
- Parametrised, round-based PRESENT block cipher core. Successor to the fixed 80-bit, encrypt-only round core.
- Adds:
  - selectable key size (80/128)
  - encrypt and decrypt modes
  - start/done handshake with a busy indication
  - on-the-fly inverse key schedule for decryption
- One PRESENT round per clock. Sits under the crypto top level as a drop-in core for either direction.

Parameters:
- KEY_WIDTH, 80, key length in bits. Only 80 or 128 are legal; any other value is an elaboration-time error.

Ports:
- clk  input  1  system clock, all state changes on the rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request a new operation; sampled only in IDLE
- mode  input  1  0 = encrypt, 1 = decrypt; sampled with start
- data_in  input  64  plaintext (encrypt) or ciphertext (decrypt); sampled with start
- key  input  KEY_WIDTH  cipher key; sampled with start
- busy  output  1  high whenever FSM is not IDLE
- done  output  1  one-cycle pulse when data_out becomes valid
- data_out  output  64  result; held until the next accepted start or reset
- round_count  output  5  current round counter value; 0 in IDLE

Behaviour:
- Reset behaviour:
  - Reset is synchronous and active-high; it dominates every other input.
  - Reset values: FSM=IDLE, busy=0, done=0, data_out=0, round_count=0, internal state/key registers cleared.
  - Reset asserted mid-operation aborts the operation. No done pulse is produced.
- FSM states: IDLE, KEYPREP, ENC, DEC.
- Accept edge E0: start=1 while in IDLE.
  - Latch data_in into the state register and key into the key register; cnt=1.
  - Go to ENC if mode=0, else KEYPREP.
- Start is ignored while busy=1; no queueing.
- Key schedule update at counter c:
  - Rotate the key register left by 61.
  - KEY_WIDTH=80: S-box on bits [79:76]; XOR c into bits [19:15].
  - KEY_WIDTH=128: S-box on [127:124] and on [123:120]; XOR c into bits [66:62].
  - Round key = key register bits [KEY_WIDTH-1:KEY_WIDTH-64].
- Inverse key update: exact inverse of the above.
  - XOR c back out, apply the inverse S-box on the same nibbles, rotate right by 61.
- Round layers:
  - S-box: PRESENT 4-bit S-box, i.e. C56B90AD3EF84712 for inputs 0..F.
  - pLayer: bit i moves to (16*i) mod 63 for i<63; bit 63 is fixed.
- ENC, edges E1..E31:
  - state <= P(S(state ^ RK)); key <= update(key, cnt); cnt++.
  - At the edge with cnt==31: data_out <= P(S(state ^ RK)) ^ RK32, where RK32 is the round key of update(key,31). Then done=1, FSM goes to IDLE.
  - Encrypt latency: done high 31 cycles after E0.
- KEYPREP, edges E1..E31:
  - key <= update(key, cnt); cnt++.
  - At the edge with cnt==31: state <= state ^ RK32; cnt <= 31; FSM goes to DEC.
- DEC, edges E32..E62:
  - Let k' = invupdate(key, cnt).
  - state <= S^-1(P^-1(state)) ^ RK(k'); key <= k'; cnt--.
  - At the edge with cnt==1: data_out gets the result, done=1, FSM goes to IDLE.
  - Decrypt latency: done high 62 cycles after E0.
- round_count mirrors cnt while busy:
  - ENC: 1..31.
  - KEYPREP: 1..31.
  - DEC: 31 down to 1.
- done is high for exactly one cycle, and busy=0 in that same cycle.
- start may be asserted in the cycle done is high. It is accepted (back-to-back operation, no dead cycle).
- Input changes after E0 do not affect the running operation.

Test Plan:
- KEY_WIDTH=80, encrypt, key=0, pt=0000000000000000 -> data_out=5579C1387B228445, done exactly 31 cycles after accept.
- KEY_WIDTH=80, encrypt, key=all-F, pt=FFFFFFFFFFFFFFFF -> 3332 5D2F... replaced by the standard vector 3333DCD3213210D2. Also key=all-F, pt=0 -> E72C46C0F5945049.
- KEY_WIDTH=80, decrypt, key=0, ct=5579C1387B228445 -> data_out=0, done 62 cycles after accept; round_count traces 1..31 then 31..1.
- KEY_WIDTH=128, encrypt, key=0, pt=0 -> 96DB702A2E6900AF. Decrypt of that result returns 0.
- Handshake:
  - start pulsed mid-operation is ignored, and the result is unchanged.
  - start asserted in the done cycle yields a second correct result 31 cycles later.
  - data_out holds its value while idle.
- Reset asserted at cycle 15 of an encrypt -> next cycle busy=0, data_out=0, round_count=0, and no done pulse.
- A start asserted together with reset is not accepted.
